// File: rtl/ahb_timer_pkg.sv
// Shared constants for the AHB system timer: register offsets, HTRANS codes
// and CS field positions.
package ahb_timer_pkg;

   // Word offsets (HADDR[7:2]) of the register map
   localparam logic [5:0] OFF_CS  = 6'h00;
   localparam logic [5:0] OFF_CLO = 6'h01;
   localparam logic [5:0] OFF_CHI = 6'h02;
   localparam logic [5:0] OFF_C0  = 6'h03;
   localparam logic [5:0] OFF_C1  = 6'h04;
   localparam logic [5:0] OFF_C2  = 6'h05;
   localparam logic [5:0] OFF_C3  = 6'h06;

   // AHB-Lite transfer types
   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   // CS layout: match flags in the low nibble, interrupt enables above them
   localparam int unsigned CS_M_LSB  = 0;
   localparam int unsigned CS_IE_LSB = 4;
   localparam int unsigned CS_WIDTH  = 8;

   // Offset of compare channel idx
   function automatic logic [5:0] cmp_offset(input int unsigned idx);
      return OFF_C0 + 6'(idx);
   endfunction

   // True for transfer types that carry a real access
   function automatic logic trans_active(input logic [1:0] trans);
      return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_timer_counter.sv
// Prescaler plus free-running 64-bit counter. tick is high on the cycle the
// prescaler sits at its terminal value; the counter advances on that edge.
module timer_counter #(
   parameter int unsigned PRESCALE    = 1,
   parameter logic [63:0] COUNT_RESET = '0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   output logic        tick,
   output logic [63:0] count
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_q;
   logic [63:0]   count_q;

   assign tick  = (presc_q == PRESC_LAST);
   assign count = count_q;

   // Prescaler wraps on tick; counter wraps silently at 2^64
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         presc_q <= '0;
         count_q <= COUNT_RESET;
      end else if (tick) begin
         presc_q <= '0;
         count_q <= count_q + 64'd1;
      end else begin
         presc_q <= presc_q + PW'(1);
      end
   end

endmodule

// File: rtl/ahb_timer.sv
// AHB-Lite system timer slave: zero-wait-state register window holding the
// compare channels, CS (enables + sticky match flags) and the CHI shadow.
module ahb_timer
   import ahb_timer_pkg::*;
#(
   parameter int unsigned PRESCALE    = 1,
   parameter int unsigned NCMP        = 4,
   // Counter start value after reset; zero in normal use
   parameter logic [63:0] COUNT_RESET = '0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        IRQ
);

   // Address-phase capture
   logic       valid_q;
   logic       write_q;
   logic [5:0] off_q;

   // Register state
   logic [31:0]     cmp_q [NCMP];
   logic [31:0]     cmp_d [NCMP];
   logic [NCMP-1:0] ie_q, ie_d;
   logic [NCMP-1:0] m_q, m_d;
   logic [31:0]     shadow_q, shadow_d;
   logic            irq_q;

   // Counter interface
   logic        tick;
   logic [63:0] count;
   logic [31:0] cnt_lo_next;

   logic wr_en;
   logic rd_en;
   logic unused_addr;

   assign unused_addr = ^{HADDR[31:8], HADDR[1:0]};

   timer_counter #(
      .PRESCALE    (PRESCALE),
      .COUNT_RESET (COUNT_RESET)
   ) u_counter (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .tick   (tick),
      .count  (count)
   );

   assign wr_en       = valid_q & write_q;
   assign rd_en       = valid_q & ~write_q;
   // Compare target: the value the counter takes on this tick
   assign cnt_lo_next = count[31:0] + 32'd1;

   assign HREADYOUT = 1'b1;
   assign IRQ       = irq_q;

   // Capture the address phase of a selected, active transfer
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         valid_q <= 1'b0;
         write_q <= 1'b0;
         off_q   <= '0;
      end else begin
         valid_q <= HSEL & trans_active(HTRANS) & HREADY;
         write_q <= HWRITE;
         off_q   <= HADDR[7:2];
      end
   end

   // Next-state for software-visible registers, match flags and shadow
   always_comb begin
      cmp_d    = cmp_q;
      ie_d     = ie_q;
      m_d      = m_q;
      shadow_d = shadow_q;

      if (wr_en) begin
         if (off_q == OFF_CS) begin
            ie_d = HWDATA[CS_IE_LSB +: NCMP];
            m_d  = m_q & ~HWDATA[CS_M_LSB +: NCMP];
         end
         for (int i = 0; i < NCMP; i++) begin
            if (off_q == cmp_offset(i)) begin
               cmp_d[i] = HWDATA;
            end
         end
      end

      // Applied after the W1C so a coincident match wins; uses old compare values
      if (tick) begin
         for (int i = 0; i < NCMP; i++) begin
            if (cnt_lo_next == cmp_q[i]) begin
               m_d[i] = 1'b1;
            end
         end
      end

      // Latch the upper half alongside the CLO value being returned
      if (rd_en && (off_q == OFF_CLO)) begin
         shadow_d = count[63:32];
      end
   end

   // Register update; IRQ follows next-state CS so it tracks the visible flags
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         for (int i = 0; i < NCMP; i++) begin
            cmp_q[i] <= '0;
         end
         ie_q     <= '0;
         m_q      <= '0;
         shadow_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         for (int i = 0; i < NCMP; i++) begin
            cmp_q[i] <= cmp_d[i];
         end
         ie_q     <= ie_d;
         m_q      <= m_d;
         shadow_q <= shadow_d;
         irq_q    <= |(m_d & ie_d);
      end
   end

   // Read data mux on the registered offset; zero outside a read data phase
   always_comb begin
      HRDATA = '0;
      if (rd_en) begin
         case (off_q)
            OFF_CS:  HRDATA = {{(32 - CS_WIDTH){1'b0}}, ie_q, m_q};
            OFF_CLO: HRDATA = count[31:0];
            OFF_CHI: HRDATA = shadow_q;
            default: HRDATA = '0;
         endcase
         for (int i = 0; i < NCMP; i++) begin
            if (off_q == cmp_offset(i)) begin
               HRDATA = cmp_q[i];
            end
         end
      end
   end

endmodule
